// File: rtl/pong_pkg.sv
// Shared types and defaults for the Pong ball engine.
//   DEF_*   : default geometry of the playfield grid
//   cell_t  : 7-bit grid cell coordinate
//   pix_t   : 10-bit pixel coordinate from VGA timing
//   state_t : ball engine game state
//   DIR_*   : 1-bit direction encoding, 1 = positive
package pong_pkg;

  localparam int unsigned DEF_CELL = 5;
  localparam int unsigned DEF_COLS = 128;
  localparam int unsigned DEF_ROWS = 96;

  typedef logic [6:0] cell_t;
  typedef logic [9:0] pix_t;

  typedef enum logic [1:0] {
    SERVE,
    PLAY,
    MISS
  } state_t;

  localparam logic DIR_POS = 1'b1;
  localparam logic DIR_NEG = 1'b0;

endpackage

// File: rtl/cell_sprite.sv
// Rectangle-in-cells pixel test.
//   cell_x, cell_y  : top-left corner of the rectangle in grid cells
//   width, height   : rectangle size in grid cells
//   h_count, v_count: pixel being scanned
//   hit             : pixel lies inside the rectangle (combinational)
module cell_sprite
  import pong_pkg::*;
#(
  parameter int unsigned CELL = DEF_CELL
) (
  input  logic [6:0] cell_x,
  input  logic [6:0] cell_y,
  input  logic [6:0] width,
  input  logic [6:0] height,
  input  logic [9:0] h_count,
  input  logic [9:0] v_count,
  output logic       hit
);

  localparam logic [10:0] CellPx = 11'(CELL);

  // 11-bit intermediates: (127 + 127) * 5 and friends never wrap.
  logic [10:0] x_lo, x_hi, y_lo, y_hi, h, v;

  always_comb begin
    x_lo = 11'(cell_x) * CellPx;
    x_hi = (11'(cell_x) + 11'(width)) * CellPx;
    y_lo = 11'(cell_y) * CellPx;
    y_hi = (11'(cell_y) + 11'(height)) * CellPx;
    h    = 11'(h_count);
    v    = 11'(v_count);
    hit  = (h >= x_lo) && (h < x_hi) && (v >= y_lo) && (v < y_hi);
  end

endmodule

// File: rtl/pong_ball_engine.sv
// Pong ball engine: owns ball position/direction, advances it on frame ticks,
// resolves wall/paddle bounces and misses, and renders ball and paddle pixels.
//   clk, rst           : pixel clock, synchronous active-high reset
//   h_count, v_count   : current pixel from VGA timing
//   frame_tick         : one pulse per frame
//   enable             : 0 freezes game state; rendering continues
//   bar_x, bar_y       : paddle left cell and row cell
//   ball_x, ball_y     : registered ball cell position
//   miss               : one-cycle pulse when the ball passes the bottom row
//   red, green, blue   : registered pixel colour (ball, 0, paddle)
module pong_ball_engine
  import pong_pkg::*;
#(
  parameter int unsigned CELL         = DEF_CELL,
  parameter int unsigned COLS         = DEF_COLS,
  parameter int unsigned ROWS         = DEF_ROWS,
  parameter int unsigned BAR_CELLS    = 6,
  parameter int unsigned SPEED_DIV    = 2,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned SPAWN_X      = 64,
  parameter int unsigned SPAWN_Y      = 48
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] h_count,
  input  logic [9:0] v_count,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic [6:0] bar_x,
  input  logic [6:0] bar_y,
  output logic [6:0] ball_x,
  output logic [6:0] ball_y,
  output logic       miss,
  output logic       red,
  output logic       green,
  output logic       blue
);

  localparam cell_t       XMax      = cell_t'(COLS - 1);
  localparam cell_t       YMax      = cell_t'(ROWS - 1);
  localparam cell_t       SpawnX    = cell_t'(SPAWN_X);
  localparam cell_t       SpawnY    = cell_t'(SPAWN_Y);
  localparam cell_t       BarW      = cell_t'(BAR_CELLS);
  localparam logic [15:0] ServeLast = 16'(SERVE_FRAMES - 1);
  localparam logic [15:0] SpeedLast = 16'(SPEED_DIV - 1);

  state_t      state_q, state_d;
  cell_t       x_q, x_d, y_q, y_d;
  logic        dx_q, dx_d, dy_q, dy_d;
  logic [15:0] frame_q, frame_d, speed_q, speed_d;
  logic        red_q, blue_q;

  logic [7:0]  bar_end;
  logic        paddle_hit;
  logic        ball_hit, bar_hit;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    frame_d = frame_q;
    speed_d = speed_q;

    // Paddle test uses the pre-step position; 8 bits so bar_x + width cannot wrap.
    bar_end    = {1'b0, bar_x} + {1'b0, BarW} - 8'd1;
    paddle_hit = (dy_q == DIR_POS) && (({1'b0, y_q} + 8'd1) == {1'b0, bar_y})
                 && (x_q >= bar_x) && ({1'b0, x_q} <= bar_end);

    if (enable) begin
      unique case (state_q)
        SERVE: begin
          if (frame_tick) begin
            if (frame_q == ServeLast) begin
              frame_d = '0;
              state_d = PLAY;
            end else begin
              frame_d = frame_q + 16'd1;
            end
          end
        end
        PLAY: begin
          if (frame_tick) begin
            if (speed_q != SpeedLast) begin
              speed_d = speed_q + 16'd1;
            end else begin
              speed_d = '0;
              if ((dy_q == DIR_POS) && (y_q == YMax) && !paddle_hit) begin
                // Ball leaves the field: position frozen, MISS handles the reload.
                state_d = MISS;
              end else begin
                if (dx_q == DIR_POS) begin
                  if (x_q == XMax) begin
                    dx_d = DIR_NEG;
                    x_d  = x_q - 7'd1;
                  end else begin
                    x_d = x_q + 7'd1;
                  end
                end else begin
                  if (x_q == '0) begin
                    dx_d = DIR_POS;
                    x_d  = 7'd1;
                  end else begin
                    x_d = x_q - 7'd1;
                  end
                end

                if (dy_q == DIR_NEG) begin
                  if (y_q == '0) begin
                    dy_d = DIR_POS;
                    y_d  = 7'd1;
                  end else begin
                    y_d = y_q - 7'd1;
                  end
                end else if (paddle_hit) begin
                  dy_d = DIR_NEG;
                  y_d  = y_q - 7'd1;
                end else begin
                  y_d = y_q + 7'd1;
                end
              end
            end
          end
        end
        MISS: begin
          // Alternate serve direction after every miss.
          x_d     = SpawnX;
          y_d     = SpawnY;
          dy_d    = DIR_NEG;
          dx_d    = ~dx_q;
          frame_d = '0;
          speed_d = '0;
          state_d = SERVE;
        end
        default: state_d = SERVE;
      endcase
    end
  end

  cell_sprite #(
    .CELL(CELL)
  ) u_ball_sprite (
    .cell_x (x_q),
    .cell_y (y_q),
    .width  (7'd1),
    .height (7'd1),
    .h_count(h_count),
    .v_count(v_count),
    .hit    (ball_hit)
  );

  cell_sprite #(
    .CELL(CELL)
  ) u_bar_sprite (
    .cell_x (bar_x),
    .cell_y (bar_y),
    .width  (BarW),
    .height (7'd1),
    .h_count(h_count),
    .v_count(v_count),
    .hit    (bar_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SERVE;
      x_q     <= SpawnX;
      y_q     <= SpawnY;
      dx_q    <= DIR_POS;
      dy_q    <= DIR_NEG;
      frame_q <= '0;
      speed_q <= '0;
      red_q   <= 1'b0;
      blue_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      frame_q <= frame_d;
      speed_q <= speed_d;
      red_q   <= ball_hit;
      blue_q  <= bar_hit & ~ball_hit;
    end
  end

  assign ball_x = x_q;
  assign ball_y = y_q;
  // Gated by enable so a frozen engine never reports a miss.
  assign miss   = (state_q == MISS) && enable;
  assign red    = red_q;
  assign green  = 1'b0;
  assign blue   = blue_q;

endmodule

// File: tb/tb_pong_ball_engine.sv
// Randomized self-checking bench for pong_ball_engine against a behavioural model.
module tb_pong_ball_engine;

  localparam int CELL = 5;
  localparam int COLS = 128;
  localparam int ROWS = 96;
  localparam int BARW = 6;
  localparam int SPD = 2;
  localparam int SERVE_N = 60;
  localparam int SX = 64;
  localparam int SY = 48;
  localparam int NCYC = 40000;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] h_count, v_count;
  logic       frame_tick, enable;
  logic [6:0] bar_x, bar_y;
  logic [6:0] ball_x, ball_y;
  logic       miss, red, green, blue;

  int n_checks = 0;
  int n_fail = 0;

  // Model: 0 = serve, 1 = play, 2 = miss
  int m_mode, m_x, m_y, m_dx, m_dy, m_serve, m_play;
  int e_red, e_blue;
  int n_miss_seen = 0;
  int n_paddle = 0;

  pong_ball_engine dut (
    .clk       (clk),
    .rst       (rst),
    .h_count   (h_count),
    .v_count   (v_count),
    .frame_tick(frame_tick),
    .enable    (enable),
    .bar_x     (bar_x),
    .bar_y     (bar_y),
    .ball_x    (ball_x),
    .ball_y    (ball_y),
    .miss      (miss),
    .red       (red),
    .green     (green),
    .blue      (blue)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_x = SX; m_y = SY; m_dx = 1; m_dy = -1; m_serve = 0; m_play = 0;
  endtask

  function automatic int inside_rect(int h, int v, int cx, int cy, int w);
    return int'(h >= cx * CELL && h < (cx + w) * CELL && v >= cy * CELL && v < (cy + 1) * CELL);
  endfunction

  // One ball move, resolved by reflecting whichever axis would leave the field.
  task automatic model_move(input int bx, input int by);
    int nx, ny, ndx, ndy;
    bit hit;
    ndx = m_dx;
    ndy = m_dy;
    nx = m_x + ndx;
    if (nx < 0 || nx > COLS - 1) begin
      ndx = -ndx;
      nx = m_x + ndx;
    end
    hit = (m_dy == 1) && (m_y + 1 == by) && (m_x >= bx) && (m_x < bx + BARW);
    if (hit) begin
      ndy = -1;
      n_paddle++;
    end
    ny = m_y + ndy;
    if (ny < 0) begin
      ndy = 1;
      ny = m_y + ndy;
    end
    if (ny > ROWS - 1) begin
      m_mode = 2;
      n_miss_seen++;
    end else begin
      m_x = nx; m_y = ny; m_dx = ndx; m_dy = ndy;
    end
  endtask

  task automatic model_edge(input bit tick, input bit en, input int bx, input int by);
    if (!en) return;
    case (m_mode)
      0: if (tick) begin
        m_serve++;
        if (m_serve == SERVE_N) begin
          m_serve = 0;
          m_mode = 1;
        end
      end
      1: if (tick) begin
        m_play++;
        if (m_play % SPD == 0) model_move(bx, by);
      end
      default: begin
        m_x = SX; m_y = SY; m_dx = -m_dx; m_dy = -1; m_serve = 0; m_play = 0;
        m_mode = 0;
      end
    endcase
  endtask

  function automatic logic [9:0] clip10(int v);
    if (v < 0) return 10'd0;
    if (v > 1023) return 10'd1023;
    return 10'(v);
  endfunction

  initial begin
    int sel, by_hold;
    rst = 1'b1; enable = 1'b1; frame_tick = 1'b0;
    h_count = '0; v_count = '0; bar_x = 7'd60; bar_y = 7'd90;
    by_hold = 90;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_eq("reset_x", int'(ball_x), SX);
    check_eq("reset_y", int'(ball_y), SY);
    check_eq("reset_miss", int'(miss), 0);
    check_eq("reset_red", int'(red), 0);
    check_eq("reset_blue", int'(blue), 0);
    check_eq("reset_green", int'(green), 0);

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      // Drive this cycle's inputs.
      rst = ($urandom_range(0, 2999) == 0) || (cyc == 30000);
      enable = !(cyc >= 20000 && cyc < 20040) && ($urandom_range(0, 19) != 0);
      frame_tick = $urandom_range(0, 1) == 1;
      if (cyc % 256 == 0) by_hold = $urandom_range(50, 96);
      bar_y = 7'(by_hold);
      if ($urandom_range(0, 4) != 0) begin
        sel = m_x - int'($urandom_range(0, BARW - 1));
        bar_x = 7'((sel < 0) ? 0 : sel);
      end else begin
        bar_x = 7'($urandom_range(0, 127));
      end
      sel = $urandom_range(0, 9);
      if (sel < 4) begin
        h_count = clip10(m_x * CELL + int'($urandom_range(0, 8)) - 2);
        v_count = clip10(m_y * CELL + int'($urandom_range(0, 8)) - 2);
      end else if (sel < 7) begin
        h_count = clip10(int'(bar_x) * CELL + int'($urandom_range(0, 40)) - 3);
        v_count = clip10(int'(bar_y) * CELL + int'($urandom_range(0, 8)) - 2);
      end else begin
        h_count = 10'($urandom_range(0, 1023));
        v_count = 10'($urandom_range(0, 1023));
      end

      @(posedge clk);
      #1;
      // Expected pixel uses the position held before this edge.
      e_red = inside_rect(int'(h_count), int'(v_count), m_x, m_y, 1);
      e_blue = inside_rect(int'(h_count), int'(v_count), int'(bar_x), int'(bar_y), BARW)
               && !e_red;
      if (rst) begin
        model_reset();
        e_red = 0;
        e_blue = 0;
      end else begin
        model_edge(frame_tick, enable, int'(bar_x), int'(bar_y));
      end

      check_eq("ball_x", int'(ball_x), m_x);
      check_eq("ball_y", int'(ball_y), m_y);
      check_eq("miss", int'(miss), int'(m_mode == 2 && enable));
      check_eq("red", int'(red), e_red);
      check_eq("blue", int'(blue), e_blue);
      check_eq("green", int'(green), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pong_ball_engine.md
Name: pong_ball_engine

Overview:
Parametrised successor to the fixed-size ball/bar pixel renderers in the Pong datapath. Owns the ball's position and direction on the cell grid and advances it once per video frame. Resolves wall bounces, paddle bounces and misses, and renders both ball and bar pixels with one registered cycle of latency. Sits between VGA timing (h_count, v_count, frame_tick) and the RGB output mux; paddle position comes from the paddle controller.

Parameters:
CELL, 5, pixel size of one grid cell; ball is 1x1 cell
COLS, 128, playfield width in cells (x range 0..COLS-1)
ROWS, 96, playfield height in cells (y range 0..ROWS-1)
BAR_CELLS, 6, paddle width in cells; paddle height is 1 cell
SPEED_DIV, 2, ball moves one cell every SPEED_DIV frame ticks (>=1)
SERVE_FRAMES, 60, frame ticks spent in SERVE before play starts
SPAWN_X, 64, serve x cell
SPAWN_Y, 48, serve y cell

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous, active-high reset
h_count  in  10  current pixel column
v_count  in  10  current pixel row
frame_tick  in  1  one-cycle pulse per frame, issued during blanking
enable  in  1  0 = freeze game state; rendering continues
bar_x  in  7  paddle left cell
bar_y  in  7  paddle row cell (>=1)
ball_x  out  7  ball cell x
ball_y  out  7  ball cell y
miss  out  1  one-cycle pulse when the ball passes the bottom row
red  out  1  ball pixel
green  out  1  always 0
blue  out  1  paddle pixel

Behaviour:
- Reset (synchronous, active-high): state=SERVE; ball_x=SPAWN_X, ball_y=SPAWN_Y; dx=+1, dy=-1; frame and speed counters=0; miss=0; red, green, blue=0.
- State changes and moves occur only on clk edges where frame_tick=1 and enable=1. enable=0 holds all state and counters, and miss stays 0.
- SERVE: count ticks. On the tick that makes the count reach SERVE_FRAMES, clear the count and go to PLAY. Position stays at spawn.
- PLAY: increment the speed counter each tick. When it reaches SPEED_DIV-1, wrap it to 0 and perform one step.
- Step: x and y are resolved independently in the same step.
  - X, dx=+1 and x==COLS-1: dx<=-1, x<=x-1.
  - X, dx=-1 and x==0: dx<=+1, x<=1.
  - X, otherwise: x<=x+dx.
  - Y, dy=-1 and y==0: dy<=+1, y<=1.
  - Y, paddle hit: dy=+1, y+1==bar_y, and bar_x<=x<=bar_x+BAR_CELLS-1. Then dy<=-1, y<=y-1. The hit test uses the pre-step x.
  - Y, miss: dy=+1, y==ROWS-1, no paddle hit. Go to MISS; position is not updated.
  - Y, otherwise: y<=y+dy.
  - Paddle hit has priority over miss when bar_y==ROWS.
- MISS: lasts exactly one clk cycle after entry.
  - miss=1 for that cycle only.
  - Reload SPAWN_X/SPAWN_Y; dy<=-1; dx toggles so serve direction alternates.
  - Clear counters and go to SERVE. Does not wait for a tick.
- Rendering, every cycle, registered (1-cycle latency from h/v_count):
  - Pixel compares use 11-bit unsigned intermediates so products and sums never wrap.
  - ball_hit = h in [x*CELL, (x+1)*CELL) and v in [y*CELL, (y+1)*CELL).
  - bar_hit = h in [bar_x*CELL, (bar_x+BAR_CELLS)*CELL) and v in [bar_y*CELL, (bar_y+1)*CELL).
  - red<=ball_hit; blue<=bar_hit & ~ball_hit (ball wins overlap); green<=0.
- ball_x and ball_y are the current registered position; they change only in the cycle after a step or reload.
- Reset mid-frame or mid-serve restores reset values on the next edge, regardless of frame_tick.

Decomposition:
- Package pong_pkg:
  - CELL, COLS, ROWS defaults
  - 7-bit cell type and 10-bit pixel type
  - state enum {SERVE, PLAY, MISS}
  - direction encoding: 1 bit, 1 = positive
- One sub-module, cell_sprite: parametrised rectangle-in-cells pixel test (inputs: cell x/y, width/height in cells, h/v_count; output: hit).
  - Instantiated twice, once for the ball and once for the bar.
  - Replaces the old per-object renderers.

Test Plan:
- Reset, then 60 ticks (SPEED_DIV=2) -> ball at (64,48) through tick 59. PLAY entered at tick 60. First step at tick 62 -> (65,47).
- Force x=127, dx=+1, y=10, dy=-1, then one step -> x=126, dx=-1, y=9. Repeat at y=0, dy=-1 -> y=1, dy=+1.
- bar_x=60, bar_y=90, ball at (65,89) with dy=+1, step -> y=88, dy=-1, no miss. Same with ball x=66 -> y=90, no bounce.
- Ball at (10,95), dy=+1, no paddle, step -> miss high exactly one cycle. Ball at (64,48), dx inverted. After SERVE_FRAMES ticks, first step moves x in the new direction.
- Ball (2,3), bar (0,3), h=10..14, v=15 -> red=1, blue=0 one cycle later. h=0..9 -> blue=1. h=30 -> blue=0. green always 0.
- enable=0 across 10 ticks -> ball_x, ball_y and counters unchanged, rendering still tracks h/v. Assert rst mid-PLAY -> next edge restores the reset values listed above.
